// File: rtl/binvention_pkg.sv
// Shared Binvention front-end constants: instruction width and the decoder
// field positions used by both fetch_unit and decoder.
package binvention_pkg;

   localparam int INSTR_W = 32;
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 14;

   // Width of a counter that must hold every value from 0 to depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a single-cycle flush; the head entry is read
// combinationally so the consumer sees it in the same cycle it becomes valid.
module fetch_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
   assign w_pop   = i_pop && (r_count != '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Binvention instruction fetch: PC, credit-limited memory requests, in-order
// response buffering and redirect handling with drop-marking of stale reads.
module fetch_unit
   import binvention_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int RESET_PC = 0,
   parameter int DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  inst_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int BUF_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] r_pc;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_drop;
   logic              r_run;

   logic [CNT_W-1:0]  w_buf_count;
   logic [CNT_W-1:0]  w_tag_count;
   logic [ADDR_W-1:0] w_tag_head;
   logic [BUF_W-1:0]  w_buf_head;
   logic [CNT_W:0]    w_credit_used;
   logic [CNT_W:0]    w_credit_limit;
   logic              w_consume;
   logic              w_req_fire;
   logic              w_rsp_drop;
   logic              w_rsp_keep;
   logic [CNT_W-1:0]  w_outstanding_next;

   assign inst_valid = (w_buf_count != '0);
   assign w_consume  = inst_valid && inst_ready;

   // A slot being consumed this cycle is lent to the next request; without
   // this, DEPTH=2 cannot sustain one instruction per cycle at latency 1.
   assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_buf_count};
   assign w_credit_limit = (CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(w_consume);
   assign imem_req_valid = r_run && (w_credit_used < w_credit_limit);
   assign imem_req_addr  = r_pc;

   assign w_req_fire = imem_req_valid && imem_req_ready;
   assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
   assign w_rsp_keep = imem_rsp_valid && (r_drop == '0);

   assign w_outstanding_next = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= ADDR_W'(RESET_PC);
         r_outstanding <= '0;
         r_drop        <= '0;
         r_run         <= 1'b0;
      end else begin
         r_run         <= 1'b1;
         r_outstanding <= w_outstanding_next;
         if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            r_pc   <= redirect_pc;
            r_drop <= w_outstanding_next;
         end else begin
            if (w_req_fire) begin
               r_pc <= r_pc + 1'b1;
            end
            r_drop <= r_drop - CNT_W'(w_rsp_drop);
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect_valid),
      .i_push  (w_req_fire),
      .i_data  (r_pc),
      .i_pop   (w_rsp_keep && (w_tag_count != '0)),
      .o_data  (w_tag_head),
      .o_count (w_tag_count)
   );

   fetch_fifo #(
      .WIDTH (BUF_W),
      .DEPTH (DEPTH)
   ) u_inst_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect_valid),
      .i_push  (w_rsp_keep),
      .i_data  ({w_tag_head, imem_rsp_data}),
      .i_pop   (w_consume),
      .o_data  (w_buf_head),
      .o_count (w_buf_count)
   );

   assign instruction = w_buf_head[INSTR_W-1:0];
   assign inst_pc     = w_buf_head[BUF_W-1:INSTR_W];

endmodule
